ram_bus_master: RTL
===================

// Module: ram_bus_master
// PURPOSE
//   Initiator for tek_yollu_bellek: drives cs/we/oe/addr and the shared
//   tristate data bus. RAM writes on posedge clk and reads on negedge.
//   Takes single-beat write requests and burst read requests from a client
//   over a valid/ready handshake. Returns read words as rd_valid pulses.
//   Sits between datapath FSMs (e.g. scaled_square) and the single-port RAM.
// PARAMETERS
//   ADDR_WIDTH  4   RAM address width; address space is 2**ADDR_WIDTH
//   DATA_WIDTH  16  RAM word width
// PORTS
//   clk        in    1           system clock; all state changes on posedge
//   reset      in    1           asynchronous, active-high reset
//   req_valid  in    1           client request present
//   req_ready  out   1           master idle; request accepted when valid&ready
//   req_we     in    1           1 = write, 0 = read
//   req_addr   in    ADDR_WIDTH  start address
//   req_len    in    ADDR_WIDTH  read beats minus 1 (0 = 1 word); ignored on write
//   req_wdata  in    DATA_WIDTH  write word
//   rd_data    out   DATA_WIDTH  captured read word
//   rd_valid   out   1           one-cycle pulse per read beat
//   wr_done    out   1           one-cycle pulse after RAM write edge
//   ram_addr   out   ADDR_WIDTH  RAM address
//   ram_data   inout DATA_WIDTH  shared bus; driven only in WRITE, else 'z
//   ram_cs     out   1           chip select
//   ram_we     out   1           write enable
//   ram_oe     out   1           output enable
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; req_ready, rd_valid, wr_done,
//     ram_cs, ram_we, ram_oe, ram_addr, rd_data = 0; ram_data = 'z.
//     req_ready rises on the first posedge after reset deasserts.
//   All outputs are registered. ram_data enable = (state==WRITE).
//   FSM states: IDLE, WRITE, READ, TURN.
//   IDLE: req_ready=1. On valid&ready at posedge, latch addr, wdata,
//     beat count = req_len. Next state is WRITE if req_we, else READ.
//   WRITE (1 cycle): cs=1, we=1, oe=0, bus=wdata. The RAM captures at the
//     closing posedge. Then go to IDLE with wr_done=1 for that cycle.
//   READ (1 cycle per beat): cs=1, we=0, oe=1, addr=current address.
//     The RAM latches at the mid-cycle negedge and drives the bus.
//     At the closing posedge: rd_data<=ram_data and rd_valid<=1.
//     If beats remain: addr<=addr+1 modulo 2**ADDR_WIDTH (wraps max->0),
//     decrement the count, stay in READ. Else go to TURN.
//   TURN (1 cycle): cs=we=oe=0, bus released by both sides. Next is IDLE.
//   Latency: read accepted at posedge P0 -> first rd_valid in the cycle
//     after P1. Beats follow back-to-back. N-beat read busy for N+1 cycles.
//     Write busy 1 cycle; wr_done coincides with req_ready returning.
//   req_ready=0 outside IDLE. Requests are neither accepted nor queued
//     then, and the client must hold req_valid.
//   Bus contention forbidden: never (state==WRITE) while cs&oe&!we.
//     TURN always separates READ from a following WRITE.
//   Reset mid-operation: burst abandoned, no further rd_valid or wr_done.
//     Bus returns to 'z immediately.
// TESTING
//   1 Write 16'hBEEF to addr 3 -> one cycle cs=we=1, bus=BEEF, wr_done
//     next. Then read addr 3 len 0 -> rd_data=BEEF, single rd_valid.
//   2 Preload mem[i]=i*16'h0101. Burst read addr 14 len 3 -> ram_addr
//     14,15,0,1. Four consecutive rd_valid with 0E0E,0F0F,0000,0101.
//   3 Read addr 5 then write addr 5 with req_valid held high ->
//     TURN cycle between them, ram_data never X, read returns old value.
//   4 Assert reset during beat 2 of a len 7 burst -> all outputs 0 and
//     bus 'z at once, no rd_valid after. req_ready=1 one posedge after release.
//   5 Hold req_valid through a len 2 read -> exactly one accept.
//     A second request is accepted only in the cycle after TURN.

Source files
------------

// File: rtl/ram_bus_master.sv
// ram_bus_master: request/handshake front end for a single-port RAM.
// Single-beat writes, burst reads, shared tristate data bus.
module ram_bus_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_len,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  wr_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_done_q, wr_done_d;
  logic                  ready_q, ready_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic                  accept;

  assign accept = req_valid & ready_q;

  // Next-state logic; strobes and RAM controls are derived
  // from the next state so every output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = req_len;
          state_d = req_we ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        wr_done_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_READ: begin
        rd_data_d  = ram_data;
        rd_valid_d = 1'b1;
        if (cnt_q != '0) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end else begin
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    cs_d    = (state_d == S_WRITE) || (state_d == S_READ);
    we_d    = (state_d == S_WRITE);
    oe_d    = (state_d == S_READ);
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      ready_q    <= 1'b0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      ready_q    <= ready_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      oe_q       <= oe_d;
    end
  end

  // Bus is driven only while writing; released otherwise.
  assign ram_data  = (state_q == S_WRITE) ? wdata_q : 'z;

  assign req_ready = ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_done   = wr_done_q;
  assign ram_addr  = addr_q;
  assign ram_cs    = cs_q;
  assign ram_we    = we_q;
  assign ram_oe    = oe_q;

endmodule
